seq_signed_divider: RTL and testbench
=====================================

Name: seq_signed_divider

Overview:
- Iterative radix-2 signed integer divider. It is the inverse datapath of the team's 32x32 signed multiplier: it takes a 2*WIDTH-bit product-width dividend and recovers the operands.
- Sits alongside the multiplier in the arithmetic chip. A start/busy/done handshake lets a controller issue one division at a time.
- The quotient is truncated toward zero. The remainder takes the sign of the dividend.

Parameters:
- WIDTH, 32, operand width. Divisor, quotient and remainder are WIDTH bits; dividend is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- dividend  input  2*WIDTH  signed two's-complement dividend; captured on the accepted start edge
- divisor  input  WIDTH  signed two's-complement divisor; captured on the accepted start edge
- busy  output  1  high from the edge after an accepted start until done falls
- done  output  1  single-cycle pulse; results are valid from this cycle
- quotient  output  WIDTH  signed quotient
- remainder  output  WIDTH  signed remainder
- div_by_zero  output  1  divisor was 0; valid with done
- overflow  output  1  true quotient does not fit in WIDTH signed bits; valid with done

Behaviour:
- Reset (async, any state):
  - state = IDLE.
  - busy, done, div_by_zero and overflow = 0.
  - quotient and remainder = 0.
  - All internal registers cleared.
  - Reset mid-division aborts the operation. No done is produced for it.
- States and transitions:
  - IDLE: start=1 at a rising edge registers the magnitudes |dividend| and |divisor|, the sign of the quotient (sign(dividend) XOR sign(divisor)) and the sign of the remainder (sign(dividend)). Clear the iteration counter, then go to CALC.
  - CALC: run 2*WIDTH restoring iterations, one per cycle. Each iteration shifts the partial remainder left, conditionally subtracts the divisor magnitude and shifts the resulting quotient bit into the quotient register. The counter wraps to FIX after the final iteration.
  - FIX: apply the sign corrections and the saturation/flag rules below, register the outputs, then go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Latency: start accepted at edge E0 → done high in the cycle after edge E0+2*WIDTH+2. For WIDTH=32 that is 66 cycles. Latency is constant regardless of operand values.
- busy is 1 in CALC, FIX and DONE, and 0 in IDLE.
- start while not in IDLE is ignored. It is neither queued nor does it disturb the operands.
- start held high across DONE→IDLE begins a new operation at the first IDLE edge. This gives back-to-back operations with one IDLE cycle between them.
- quotient, remainder and the flags hold their values from the last done until the next FIX, or until reset.
- Divide by zero:
  - div_by_zero=1, overflow=0.
  - quotient = all ones (-1).
  - remainder = dividend[WIDTH-1:0].
  - Latency is unchanged.
- Overflow (the signed quotient is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1], e.g. -2^(2W-1) / -1):
  - overflow=1.
  - quotient saturates to 2^(WIDTH-1)-1 if the true result is positive, or to -2^(WIDTH-1) if negative.
  - remainder = 0.
- Magnitude arithmetic:
  - The internal dividend magnitude is 2*WIDTH bits unsigned, so the most negative dividend is representable.
  - The partial remainder is WIDTH+1 bits.
  - The internal quotient is 2*WIDTH bits before the range check.
- Identity, when neither flag is set: dividend == quotient*divisor + remainder, |remainder| < |divisor|, and remainder is 0 or has the sign of the dividend.

Test Plan:
- Reset: rst=1 for 2 cycles with start=1 → all outputs 0 and busy=0. Release rst, pulse start with dividend=-15, divisor=-3 → done exactly 66 cycles later with quotient=5, remainder=0, no flags.
- Sign combinations, each with the expected quotient and remainder:
  - 16/8 → 2, 0
  - 12/-4 → -3, 0
  - -42/7 → -6, 0
  - -7/2 → -3, -1
  - 7/-2 → -3, 1
- Corner values:
  - Divide by zero: dividend=-5, divisor=0 → div_by_zero=1, quotient=32'hFFFFFFFF, remainder=-5, constant latency.
  - Overflow: dividend=64'h8000000000000000, divisor=-1 → overflow=1, quotient=32'h7FFFFFFF, remainder=0.
  - 0 / -5 → quotient 0, remainder 0.
- Handshake:
  - Pulse start again at cycle 10 of a busy operation with different operands → ignored; the first result is unchanged.
  - Start held high → second done arrives 67 cycles after the first.
- Mid-operation reset: assert rst at CALC cycle 20 → outputs clear immediately (asynchronously), with no done pulse. A new start then completes normally.
- Random cross-check: feed 1000 random signed 32x32 products from the multiplier model as the dividend, with the multiplier operand as the divisor (nonzero) → quotient equals the other operand and remainder is 0.

Source files
------------

// File: rtl/seq_signed_divider.sv
// Iterative radix-2 restoring signed divider: 2*WIDTH-bit dividend over WIDTH-bit divisor,
// quotient truncated toward zero, remainder carries the dividend's sign, saturating on overflow.
`timescale 1ns/1ps
module seq_signed_divider #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero,
    output logic               overflow
);
    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // Dividend magnitude shifts out of the top while quotient bits shift in at the bottom.
    logic [DW-1:0]    quo_q, quo_d;
    logic [WIDTH:0]   prem_q, prem_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             take;
    logic [WIDTH-1:0] rem_mag;
    logic             q_big;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        quo_d       = quo_q;
        prem_d      = prem_q;
        dvsr_d      = dvsr_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        busy_d      = (state_q != IDLE);
        done_d      = (state_q == DONE);

        shifted = {prem_q[WIDTH-1:0], quo_q[DW-1]};
        diff    = {1'b0, shifted} - {2'b00, dvsr_q};
        take    = ~diff[WIDTH+1];
        rem_mag = prem_q[WIDTH-1:0];
        // Magnitude limit is 2^(W-1) for a negative result, 2^(W-1)-1 for a positive one.
        q_big   = (quo_q[DW-1:WIDTH] != '0) ||
                  (quo_q[WIDTH-1] && (!q_neg_q || (quo_q[WIDTH-2:0] != '0)));

        case (state_q)
            IDLE: begin
                if (start) begin
                    quo_d   = dividend[DW-1] ? -dividend : dividend;
                    dvsr_d  = divisor[WIDTH-1] ? -divisor : divisor;
                    q_neg_d = dividend[DW-1] ^ divisor[WIDTH-1];
                    r_neg_d = dividend[DW-1];
                    prem_d  = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                prem_d = take ? diff[WIDTH:0] : shifted;
                quo_d  = {quo_q[DW-2:0], take};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(DW - 1)) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end
            end
            FIX: begin
                if (dvsr_q == '0) begin
                    // A zero divisor never restores, so the partial remainder ends holding
                    // |dividend|[W-1:0]; re-signing it yields dividend[W-1:0].
                    dbz_d       = 1'b1;
                    ovf_d       = 1'b0;
                    quotient_d  = '1;
                    remainder_d = r_neg_q ? -rem_mag : rem_mag;
                end else if (q_big) begin
                    dbz_d       = 1'b0;
                    ovf_d       = 1'b1;
                    quotient_d  = q_neg_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                    remainder_d = '0;
                end else begin
                    dbz_d       = 1'b0;
                    ovf_d       = 1'b0;
                    quotient_d  = q_neg_q ? -quo_q[WIDTH-1:0] : quo_q[WIDTH-1:0];
                    remainder_d = r_neg_q ? -rem_mag : rem_mag;
                end
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            quo_q       <= '0;
            prem_q      <= '0;
            dvsr_q      <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            quo_q       <= quo_d;
            prem_q      <= prem_d;
            dvsr_q      <= dvsr_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider: wide-integer reference model checked on every
// done pulse, plus hand-computed literals, latency, handshake and mid-operation reset checks.
`timescale 1ns/1ps
module tb_seq_signed_divider;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] dividend;
    logic [31:0] divisor;
    logic        busy, done, div_by_zero, overflow;
    logic [31:0] quotient, remainder;

    int n_vec = 0;
    int n_mis = 0;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];

    seq_signed_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference: exact wide signed division, then the range/zero rules.
    function automatic exp_t model(input logic signed [63:0] n, input logic signed [31:0] d);
        exp_t e;
        logic signed [127:0] nw, dw, qw, rw;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        if (d == 0) begin
            e.dbz = 1'b1;
            e.q   = 32'hFFFF_FFFF;
            e.r   = n[31:0];
        end else begin
            nw = n;
            dw = d;
            qw = nw / dw;
            rw = nw % dw;
            if (qw > 128'sd2147483647 || qw < -128'sd2147483648) begin
                e.ovf = 1'b1;
                e.q   = (qw < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                e.r   = 32'h0;
            end else begin
                e.q = qw[31:0];
                e.r = rw[31:0];
            end
        end
        return e;
    endfunction

    // Compare process: every done pulse is checked against the oldest outstanding request.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                if (exp_q.size() == 0) begin
                    check("done without request", {63'b0, done}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("model quotient", quotient, e.q);
                    check("model remainder", remainder, e.r);
                    check("model div_by_zero", div_by_zero, e.dbz);
                    check("model overflow", overflow, e.ovf);
                end
            end
        end
    end

    task automatic issue(input logic [63:0] dvd, input logic [31:0] dvs);
        @(negedge clk);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(posedge clk);
        exp_q.push_back(model(dvd, dvs));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts rising edges since the accepting edge until done is seen (bounded).
    task automatic wait_done(input int from, output int lat);
        lat = from;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 200);
    endtask

    task automatic check_lit(input string name, input logic [31:0] lq, input logic [31:0] lr,
                             input logic ldbz, input logic lovf);
        check({name, " quotient"}, quotient, lq);
        check({name, " remainder"}, remainder, lr);
        check({name, " div_by_zero"}, div_by_zero, ldbz);
        check({name, " overflow"}, overflow, lovf);
    endtask

    task automatic run_op(input string name, input logic [63:0] dvd, input logic [31:0] dvs,
                          input logic [31:0] lq, input logic [31:0] lr,
                          input logic ldbz, input logic lovf);
        int lat;
        issue(dvd, dvs);
        @(negedge clk);
        check({name, " busy"}, busy, 1'b1);
        wait_done(1, lat);
        check({name, " latency"}, lat, 66);
        check_lit(name, lq, lr, ldbz, lovf);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, gap, n_done;
        logic signed [31:0] a, b;
        logic signed [63:0] pa, pb;

        rst      = 1'b1;
        start    = 1'b1;
        dividend = 64'd100;
        divisor  = 32'd7;
        repeat (2) @(negedge clk);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset quotient", quotient, 32'h0);
        check("reset remainder", remainder, 32'h0);
        check("reset flags", {div_by_zero, overflow}, 2'b00);
        rst   = 1'b0;
        start = 1'b0;

        run_op("neg/neg", -64'sd15, -32'sd3, 32'd5, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("busy after done", busy, 1'b0);

        run_op("16/8", 64'sd16, 32'sd8, 32'd2, 32'd0, 1'b0, 1'b0);
        run_op("12/-4", 64'sd12, -32'sd4, 32'hFFFF_FFFD, 32'd0, 1'b0, 1'b0);
        run_op("-42/7", -64'sd42, 32'sd7, 32'hFFFF_FFFA, 32'd0, 1'b0, 1'b0);
        run_op("-7/2", -64'sd7, 32'sd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("7/-2", 64'sd7, -32'sd2, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
        run_op("div0", -64'sd5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1'b0);
        run_op("ovf min/-1", 64'h8000_0000_0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b1);
        run_op("ovf neg", 64'h0000_0001_0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
        run_op("ovf 2^31/1", 64'h0000_0000_8000_0000, 32'd1, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b1);
        run_op("-2^31/1", 64'hFFFF_FFFF_8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
        run_op("0/-5", 64'd0, -32'sd5, 32'd0, 32'd0, 1'b0, 1'b0);

        // start pulsed at cycle 10 of a busy operation must be ignored
        issue(64'sd100, 32'sd9);
        repeat (9) @(negedge clk);
        start    = 1'b1;
        dividend = 64'sd77;
        divisor  = -32'sd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(10, lat);
        check("ignored start latency", lat, 66);
        check_lit("ignored start", 32'd11, 32'd1, 1'b0, 1'b0);
        n_done = 0;
        repeat (70) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("ignored start extra done", n_done, 0);

        // start held high: back-to-back operations one IDLE cycle apart
        @(negedge clk);
        start    = 1'b1;
        dividend = -64'sd1000;
        divisor  = 32'sd33;
        @(posedge clk);
        exp_q.push_back(model(-64'sd1000, 32'sd33));
        @(negedge clk);
        dividend = 64'sd12345;
        divisor  = -32'sd100;
        wait_done(0, lat);
        check("b2b first latency", lat, 66);
        check_lit("b2b first", 32'hFFFF_FFE2, 32'hFFFF_FFF6, 1'b0, 1'b0);
        @(posedge clk);
        exp_q.push_back(model(64'sd12345, -32'sd100));
        @(negedge clk);
        start = 1'b0;
        wait_done(1, gap);
        check("b2b done spacing", gap, 67);
        check_lit("b2b second", 32'hFFFF_FF85, 32'd45, 1'b0, 1'b0);

        // asynchronous reset in the middle of CALC aborts the operation
        issue(64'sd500, 32'sd3);
        repeat (20) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst busy", busy, 1'b0);
        check("midrst quotient", quotient, 32'h0);
        check("midrst remainder", remainder, 32'h0);
        check("midrst flags", {done, div_by_zero, overflow}, 3'b000);
        exp_q.delete();
        @(negedge clk);
        rst    = 1'b0;
        n_done = 0;
        repeat (80) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("midrst no done", n_done, 0);
        run_op("after midrst", 64'sd500, 32'sd3, 32'd166, 32'd2, 1'b0, 1'b0);

        // products from the multiplier model divide back to the other operand
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = (i % 4 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (i % 8 == 1) b = -b;
            if (b == 0) b = 32'sd1;
            pa = a;
            pb = b;
            run_op("random", pa * pb, b, a, 32'd0, 1'b0, 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
